// File: rtl/cpu8_pkg.sv
// Shared types and default widths for the 8-bit computer.
package cpu8_pkg;

  localparam int CPU8_ADDR_W = 4;
  localparam int CPU8_DATA_W = 8;

  typedef enum logic [3:0] {
    OP_LDA, OP_LDB, OP_LDO, OP_STA,
    OP_STB, OP_STI, OP_ADD, OP_SUB,
    OP_INC, OP_DEC, OP_AND, OP_OR,
    OP_XOR, OP_NOT, OP_JMP, OP_HLT
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH, S_EXEC, S_WAIT_IN, S_HALT
  } state_e;

endpackage

// File: rtl/cpu8_alu.sv
// Combinational ALU: result, carry/borrow and zero for the ALU opcodes.
module cpu8_alu
  import cpu8_pkg::*;
#(
  parameter int DATA_W = CPU8_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  opcode_e           op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              c_o,
  output logic              z_o
);

  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  logic [DATA_W:0] wide;

  // Top bit of the widened result is carry for add, borrow for subtract
  always_comb begin
    wide = {1'b0, a_i};
    unique case (op_i)
      OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
      OP_INC:  wide = {1'b0, a_i} + ONE;
      OP_DEC:  wide = {1'b0, a_i} - ONE;
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_OR:   wide = {1'b0, a_i | b_i};
      OP_XOR:  wide = {1'b0, a_i ^ b_i};
      OP_NOT:  wide = {1'b0, ~a_i};
      default: wide = {1'b0, a_i};
    endcase
  end

  assign res_o = wide[DATA_W-1:0];
  assign c_o   = wide[DATA_W];
  assign z_o   = (res_o == '0);

endmodule

// File: rtl/cpu8_control_unit.sv
// Fetch/execute sequencer: owns PC, IR, A, B, output reg and flags.
module cpu8_control_unit
  import cpu8_pkg::*;
#(
  parameter int ADDR_W = CPU8_ADDR_W,
  parameter int DATA_W = CPU8_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              ov_q, ov_d;

  logic [ADDR_W-1:0] addr_c;
  logic              rd_c, wr_c, rdy_c;
  logic [DATA_W-1:0] wdata_c;

  opcode_e           op;
  logic [ADDR_W-1:0] opnd;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_z;

  assign op   = opcode_e'(ir_q[DATA_W-1 -: 4]);
  assign opnd = ir_q[ADDR_W-1:0];

  cpu8_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (op),
    .res_o (alu_res),
    .c_o   (alu_c),
    .z_o   (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    z_d     = z_q;
    c_d     = c_q;
    ov_d    = 1'b0;
    addr_c  = '0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    wdata_c = '0;
    rdy_c   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        addr_c  = pc_q;
        rd_c    = 1'b1;
        ir_d    = mem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        unique case (op)
          OP_LDA, OP_LDB, OP_LDO: begin
            addr_c = opnd;
            rd_c   = 1'b1;
            if (op == OP_LDA) a_d = mem_rdata;
            if (op == OP_LDB) b_d = mem_rdata;
            if (op == OP_LDO) begin
              out_d = mem_rdata;
              ov_d  = 1'b1;
            end
          end
          OP_STA, OP_STB: begin
            addr_c  = opnd;
            wr_c    = 1'b1;
            wdata_c = (op == OP_STA) ? a_q : b_q;
          end
          OP_STI: state_d = S_WAIT_IN;
          OP_ADD, OP_SUB, OP_INC, OP_DEC,
          OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            a_d = alu_res;
            z_d = alu_z;
            c_d = alu_c;
          end
          OP_JMP: pc_d = opnd;
          OP_HLT: state_d = S_HALT;
        endcase
      end
      S_WAIT_IN: begin
        rdy_c = in_valid;
        if (in_valid) begin
          addr_c  = opnd;
          wr_c    = 1'b1;
          wdata_c = in_data;
          state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
    endcase
  end

  // Bus strobes fall with rst_n itself, not at the next edge
  assign mem_addr  = rst_n ? addr_c : '0;
  assign mem_rd_en = rst_n & rd_c;
  assign mem_wr_en = rst_n & wr_c;
  assign mem_wdata = rst_n ? wdata_c : '0;
  assign in_ready  = rst_n & rdy_c;

  assign out_data  = out_q;
  assign out_valid = ov_q;
  assign reg_a     = a_q;
  assign reg_b     = b_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu8_control_unit.sv
// Scoreboard bench for cpu8_control_unit with a 16x8 RAM model.
module tb_cpu8_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mem_addr;
  logic       mem_rd_en, mem_wr_en;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic [7:0] reg_a, reg_b;
  logic       flag_z, flag_c, halted;

  always #5 clk = ~clk;

  cpu8_control_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .halted    (halted)
  );

  logic [7:0]  ram  [16];
  logic [7:0]  prog [16];
  logic        ld = 1'b0;
  logic [11:0] exp_wr [$];
  logic [7:0]  exp_out [$];
  logic [11:0] e_wr;
  logic [7:0]  e_out;
  int          n_chk = 0;
  int          n_fail = 0;
  int          rdy_cnt = 0;

  assign mem_rdata = mem_rd_en ? ram[mem_addr] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 16; i++) ram[i] = prog[i];
    end else if (mem_wr_en) begin
      if (exp_wr.size() == 0)
        chk("wr_unexpected", {20'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      else begin
        e_wr = exp_wr.pop_front();
        chk("wr", {20'h0, mem_addr, mem_wdata}, {20'h0, e_wr});
      end
      ram[mem_addr] = mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mem_rd_en && mem_wr_en) chk("rd_wr_excl", 32'(mem_wr_en), 0);
    if (in_ready) rdy_cnt++;
    if (out_valid) begin
      if (exp_out.size() == 0)
        chk("out_unexpected", 32'(out_data), 32'hFFFF_FFFF);
      else begin
        e_out = exp_out.pop_front();
        chk("out", 32'(out_data), 32'(e_out));
      end
    end
  end

  task automatic clr_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  task automatic hold_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ld       = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    rdy_cnt = 0;
    #1;
    chk("first_fetch_addr", 32'(mem_addr), 0);
    chk("first_fetch_rd", 32'(mem_rd_en), 1);
  endtask

  task automatic wait_halt(input int max);
    int n = 0;
    while (!halted && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!halted) chk("halt_timeout", 32'(halted), 1);
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_wr_left"}, 32'(exp_wr.size()), 0);
    chk({tag, "_out_left"}, 32'(exp_out.size()), 0);
  endtask

  initial begin
    // LDA 15, LDB 14, ADD, STA 11, HLT; input held but never requested
    clr_prog();
    prog[0] = 8'h0F; prog[1] = 8'h1E; prog[2] = 8'h60;
    prog[3] = 8'h3B; prog[4] = 8'hF0;
    prog[15] = 8'h03; prog[14] = 8'h01;
    hold_reset();
    chk("rst_rd", 32'(mem_rd_en), 0);
    chk("rst_wr", 32'(mem_wr_en), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_regs", {reg_a, reg_b, out_data, 6'h0, flag_z, flag_c}, 0);
    exp_wr.push_back({4'd11, 8'h04});
    in_valid = 1'b1;
    in_data  = 8'hAA;
    release_reset();
    repeat (9) @(posedge clk);
    #1 chk("halt_early", 32'(halted), 0);
    @(posedge clk);
    #1 chk("halt_at_10", 32'(halted), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_ram11", 32'(ram[11]), 32'h04);
    chk("t1_a", 32'(reg_a), 32'h04);
    chk("t1_b", 32'(reg_b), 32'h01);
    chk("t1_zc", {30'h0, flag_z, flag_c}, 0);
    chk("t1_ready_ignored", 32'(rdy_cnt), 0);
    chk("t1_halt_bus", {30'h0, mem_rd_en, mem_wr_en}, 0);
    queues_empty("t1");

    // INC wraps 0xFF to 0, then DEC borrows back to 0xFF
    clr_prog();
    prog[0] = 8'h0F; prog[1] = 8'h80; prog[2] = 8'h90;
    prog[3] = 8'hF0; prog[15] = 8'hFF;
    hold_reset();
    release_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("inc_a", 32'(reg_a), 0);
    chk("inc_zc", {30'h0, flag_z, flag_c}, 32'b11);
    repeat (2) @(posedge clk);
    #1;
    chk("dec_a", 32'(reg_a), 32'hFF);
    chk("dec_zc", {30'h0, flag_z, flag_c}, 32'b01);
    wait_halt(10);
    queues_empty("t2");

    // STI 15 stalls five cycles, then takes 0x07
    clr_prog();
    prog[0] = 8'h5F; prog[1] = 8'hF0;
    hold_reset();
    exp_wr.push_back({4'd15, 8'h07});
    release_reset();
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(in_ready), 0);
      chk("stall_bus", {30'h0, mem_rd_en, mem_wr_en}, 0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h07;
    #1;
    chk("sti_ready", 32'(in_ready), 1);
    chk("sti_bus", {19'h0, mem_wr_en, mem_addr, mem_wdata}, {19'h0, 1'b1, 4'd15, 8'h07});
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_halt(10);
    chk("sti_ram15", 32'(ram[15]), 32'h07);
    chk("sti_ready_pulses", 32'(rdy_cnt), 1);
    queues_empty("t3");

    // STI, LDA, then INC/STA/LDO/JMP loop counting up from the input
    clr_prog();
    prog[0] = 8'h5F; prog[1] = 8'h0F; prog[2] = 8'h80;
    prog[3] = 8'h3F; prog[4] = 8'h2F; prog[5] = 8'hE2;
    hold_reset();
    exp_wr.push_back({4'd15, 8'h05});
    for (int v = 6; v <= 9; v++) begin
      exp_wr.push_back({4'd15, 8'(v)});
      exp_out.push_back(8'(v));
    end
    in_valid = 1'b1;
    in_data  = 8'h05;
    release_reset();
    begin
      int n = 0;
      while (exp_out.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    chk("loop_ready_pulses", 32'(rdy_cnt), 1);
    queues_empty("t4");

    // Non-jump at address 15 wraps the next fetch to 0
    clr_prog();
    prog[0] = 8'hEF; prog[15] = 8'h80;
    hold_reset();
    release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("jmp15_addr", 32'(mem_addr), 15);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wrap_addr", 32'(mem_addr), 0);
    chk("wrap_rd", 32'(mem_rd_en), 1);
    chk("wrap_a", 32'(reg_a), 1);

    // Reset asserted while STA drives the bus cancels the write
    clr_prog();
    prog[0] = 8'h0F; prog[1] = 8'h3B; prog[15] = 8'h5A;
    hold_reset();
    release_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sta_bus", {19'h0, mem_wr_en, mem_addr, mem_wdata}, {19'h0, 1'b1, 4'd11, 8'h5A});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus", {19'h0, mem_wr_en, mem_addr, mem_wdata}, 0);
    chk("rst_mid_ctl", {28'h0, mem_rd_en, in_ready, out_valid, halted}, 0);
    chk("rst_mid_a", 32'(reg_a), 0);
    @(posedge clk);
    #1 chk("rst_mid_ram11", 32'(ram[11]), 0);
    release_reset();
    queues_empty("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
